// File: rtl/audio_sdm_out_pkg.sv
// Shared constants and gain FSM state type for the audio output stage.
// Optional second-order modulator is selected with AUDIO_SDM2_EN (see sdm_core).
package audio_pkg;

    localparam int SAMPLE_W = 7;
    localparam int GAIN_W   = 8;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 8'd128;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } gain_state_e;

endpackage

// File: rtl/audio_sdm_out_if.sv
// Mixer-to-audio-stage bundle: sample/strobe/mute in, modulator bit and status out.
interface audio_sdm_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_stb;
    logic                mute;
    logic                pwm_out;
    logic                ramp_active;
    logic                muted;

    modport master (
        output sample_in, sample_stb, mute,
        input  pwm_out, ramp_active, muted
    );

    modport slave (
        input  sample_in, sample_stb, mute,
        output pwm_out, ramp_active, muted
    );

endinterface

// File: rtl/audio_sdm_out_sdm_core.sv
// Sigma-delta modulator: first-order accumulator by default, second-order
// error-feedback loop with saturating integrators when AUDIO_SDM2_EN is defined.
module sdm_core
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] scaled,
    output logic                pwm_out
);

`ifdef AUDIO_SDM2_EN
    logic signed [9:0]  i1_r;
    logic signed [11:0] i2_r;
    logic signed [12:0] i1_sum_s;
    logic signed [13:0] i2_sum_s;
    logic signed [9:0]  i1_nxt_s;
    logic signed [11:0] i2_nxt_s;
    logic [7:0]         fb_s;

    function automatic logic signed [9:0] sat_i1(input logic signed [12:0] v);
        if (v > 13'sd511)       return 10'sd511;
        else if (v < -13'sd512) return -10'sd512;
        else                    return v[9:0];
    endfunction

    function automatic logic signed [11:0] sat_i2(input logic signed [13:0] v);
        if (v > 14'sd2047)       return 12'sd2047;
        else if (v < -14'sd2048) return -12'sd2048;
        else                     return v[11:0];
    endfunction

    // Integrator updates; feedback is the previous output bit at full scale.
    always_comb begin
        fb_s     = pwm_out ? 8'd128 : 8'd0;
        i1_sum_s = {{3{i1_r[9]}}, i1_r} + {6'd0, scaled} - {5'd0, fb_s};
        i1_nxt_s = sat_i1(i1_sum_s);
        i2_sum_s = {{2{i2_r[11]}}, i2_r} + {{4{i1_nxt_s[9]}}, i1_nxt_s} - {6'd0, fb_s};
        i2_nxt_s = sat_i2(i2_sum_s);
    end

    // Integrator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_r    <= 10'sd0;
            i2_r    <= 12'sd0;
            pwm_out <= 1'b0;
        end else begin
            i1_r    <= i1_nxt_s;
            i2_r    <= i2_nxt_s;
            pwm_out <= ~i2_nxt_s[11];
        end
    end
`else
    logic [SAMPLE_W-1:0] acc_r;
    logic [SAMPLE_W:0]   sum_s;

    // Carry out of the 7-bit accumulator is the density bit.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, scaled};
    end

    // Accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 7'd0;
            pwm_out <= 1'b0;
        end else begin
            acc_r   <= sum_s[SAMPLE_W-1:0];
            pwm_out <= sum_s[SAMPLE_W];
        end
    end
`endif

endmodule

// File: rtl/audio_sdm_out.sv
// Audio output stage: sample capture, soft-start/mute gain ramp, scaling and
// sigma-delta modulation (order selected by AUDIO_SDM2_EN inside sdm_core).
module audio_sdm_out
    import audio_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    audio_sdm_if.slave bus
);

    gain_state_e         state_r;
    gain_state_e         state_nxt_s;
    logic [GAIN_W-1:0]   gain_r;
    logic [GAIN_W-1:0]   gain_nxt_s;
    logic [SAMPLE_W-1:0] cur_sample_r;
    logic [SAMPLE_W-1:0] scaled_r;
    logic [14:0]         product_s;
    logic                ramp_active_r;
    logic                muted_r;
    logic                pwm_s;

    // Gain FSM: the gain step direction follows the state held before the edge.
    always_comb begin
        state_nxt_s = state_r;
        gain_nxt_s  = gain_r;
        case (state_r)
            MUTED: begin
                if (!bus.mute) state_nxt_s = RAMP_UP;
                else           state_nxt_s = MUTED;
            end
            RAMP_UP: begin
                if (bus.sample_stb && (gain_r < GAIN_ONE)) gain_nxt_s = gain_r + 8'd1;
                else                                       gain_nxt_s = gain_r;
                if (bus.mute)                                           state_nxt_s = RAMP_DOWN;
                else if (bus.sample_stb && (gain_nxt_s == GAIN_ONE))    state_nxt_s = RUN;
                else                                                    state_nxt_s = RAMP_UP;
            end
            RUN: begin
                if (bus.mute) state_nxt_s = RAMP_DOWN;
                else          state_nxt_s = RUN;
            end
            RAMP_DOWN: begin
                if (bus.sample_stb && (gain_r > 8'd0)) gain_nxt_s = gain_r - 8'd1;
                else                                   gain_nxt_s = gain_r;
                if (!bus.mute)                                      state_nxt_s = RAMP_UP;
                else if (bus.sample_stb && (gain_nxt_s == 8'd0))    state_nxt_s = MUTED;
                else                                                state_nxt_s = RAMP_DOWN;
            end
            default: begin
                state_nxt_s = MUTED;
                gain_nxt_s  = 8'd0;
            end
        endcase
    end

    // 7x8 product; cannot exceed 15 bits since gain tops out at 128.
    always_comb begin
        product_s = {8'd0, cur_sample_r} * {7'd0, gain_r};
    end

    // State, gain, capture, scaling and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= MUTED;
            gain_r        <= 8'd0;
            cur_sample_r  <= 7'd0;
            scaled_r      <= 7'd0;
            ramp_active_r <= 1'b0;
            muted_r       <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            gain_r   <= gain_nxt_s;
            scaled_r <= SAMPLE_W'(product_s >> 4'd7);
            if (bus.sample_stb) cur_sample_r <= bus.sample_in;
            else                cur_sample_r <= cur_sample_r;
            ramp_active_r <= (state_nxt_s == RAMP_UP) || (state_nxt_s == RAMP_DOWN);
            muted_r       <= (state_nxt_s == MUTED);
        end
    end

    sdm_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .scaled  (scaled_r),
        .pwm_out (pwm_s)
    );

    assign bus.pwm_out     = pwm_s;
    assign bus.ramp_active = ramp_active_r;
    assign bus.muted       = muted_r;

endmodule

// File: doc/audio_sdm_out.md
# audio_sdm_out

Audio output stage downstream of the tune synthesiser: accepts the summed 7-bit unsigned voice sample once per scanline and turns it into a 1-bit density stream on the audio pin. Provides click-free soft start after reset and a mute ramp, then drives a sigma-delta modulator clocked at the pixel clock. Sits between the voice mixer (`sample_in`/`sample_stb`) and `uio_out[7]`.

## Interface
- `SAMPLE_W`, 7: sample width; full scale is 2^SAMPLE_W.
- `GAIN_W`, 8: gain register width; unity gain is 128.
- `clk`  in  1  pixel clock (25.175 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_in`  in  SAMPLE_W  unsigned mixer output, 0..126 in practice.
- `sample_stb`  in  1  one-cycle strobe, one per scanline; captures `sample_in`.
- `mute`  in  1  level request; 1 = fade to silence, 0 = fade to unity.
- `pwm_out`  out  1  registered modulator bit.
- `ramp_active`  out  1  high while in RAMP_UP or RAMP_DOWN.
- `muted`  out  1  high in MUTED.

## Operation
- Reset: `cur_sample`=0, `gain`=0, `scaled`=0, integrators=0, state=MUTED, `pwm_out`=0, `ramp_active`=0, `muted`=1.
- Capture: `sample_stb` high -> `cur_sample` <= `sample_in`; held otherwise.
- Gain FSM (MUTED, RAMP_UP, RUN, RAMP_DOWN), evaluated every clk:
  - MUTED: `mute`=0 -> RAMP_UP.
  - RAMP_UP: `mute`=1 -> RAMP_DOWN (reverses from current gain). Else on `sample_stb`: gain+1; if new gain==128 -> RUN same edge.
  - RUN: `mute`=1 -> RAMP_DOWN.
  - RAMP_DOWN: `mute`=0 -> RAMP_UP. Else on `sample_stb`: gain-1; if new gain==0 -> MUTED same edge.
  - Gain steps only on `sample_stb`, using the state held before the edge; a `mute` change coincident with a strobe changes state but the step follows the old state's direction.
  - Gain saturates: never below 0 nor above 128.
- Scaling: `scaled` <= (`cur_sample` * `gain`) >> 7, truncating, SAMPLE_W bits; product is 15 bits, no overflow possible.
- First-order modulator (default): 7-bit `acc`; sum = `acc` + `scaled` (8 bits); `acc` <= sum[6:0]; `pwm_out` <= sum[7]. Long-run density = `scaled`/128 exactly.

## Timing
- `sample_stb` edge N -> `cur_sample` valid after N; `scaled` after N+1; first modulator use at N+2; `pwm_out` reflects it after N+2.
- Fully synchronous apart from reset; no combinational input-to-output path.
- Reset mid-operation: all state returns to reset values asynchronously; `pwm_out` drops to 0 immediately.
- `sample_stb` on consecutive cycles legal; each captures and steps gain.

## Configuration
- `AUDIO_SDM2_EN` defined: second-order error-feedback modulator replaces the accumulator. Feedback y = `pwm_out` ? 128 : 0. `i1` signed 10-bit, `i2` signed 12-bit, both saturating at their limits. `i1` <= `i1` + `scaled` - y; `i2` <= `i2` + `i1_next` - y; `pwm_out` <= (`i2_next` >= 0). Same density, noise shaped away from audio band.
- Not defined: first-order accumulator above; integrator registers absent.

## Structure
- Shared package `audio_pkg`: `GAIN_ONE`=128, `SAMPLE_W`, gain FSM state enum (2-bit, MUTED=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3).
- One sub-module `sdm_core`: input `scaled`, output `pwm_out`; holds accumulator/integrators and the `AUDIO_SDM2_EN` switch. FSM, capture and scaling live in the top.

## Test plan
- Reset, `mute`=0, `sample_in`=64, strobe every 800 clks -> `ramp_active`=1 for 128 strobes, gain 128, state RUN; then first-order `pwm_out` count exactly 640 in 1280 clks.
- RUN, `sample_in`=0 -> `pwm_out` constant 0; `sample_in`=126 -> exactly 126 ones per 128 clks.
- RAMP_UP at gain 40, assert `mute` -> RAMP_DOWN; after 40 strobes `muted`=1, gain 0, `pwm_out` 0 thereafter.
- `mute` falls on same edge as a strobe in RAMP_DOWN at gain 10 -> gain 9, state RAMP_UP; next strobe gain 10.
- `rst_n` pulsed low mid-RUN -> `pwm_out`=0, `muted`=1, gain 0 without a clock edge.
- `AUDIO_SDM2_EN`, gain 128, `sample_in`=32 -> 1024±2 ones in 4096 clks; `i1`, `i2` never hit saturation.
